hs_slave_fifo: RTL
==================

HS_SLAVE_FIFO -- requirements
Module: hs_slave_fifo

Interface
REQ-001 Parameter L, default 8, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, buffer entries; power of two, >=2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset; sampled on rising clk edge only.
REQ-005 ren  input  1  receive enable; gates acceptance of new words.
REQ-006 flush  input  1  synchronous clear of buffered contents.
REQ-007 s_valid  input  1  upstream word present.
REQ-008 s_ready  output  1  block can accept a word this cycle.
REQ-009 s_data  input  L  upstream data.
REQ-010 m_valid  output  1  buffered word available downstream.
REQ-011 m_ready  input  1  downstream accepts word.
REQ-012 m_data  output  L  head-of-buffer data.
REQ-013 count  output  $clog2(DEPTH)+1  number of words held.
REQ-014 full, empty  output  1 each  count==DEPTH / count==0.
REQ-015 ovf_sticky  output  1  set on any cycle with s_valid=1, ren=1, full=1; cleared only by rst or flush.

Function
REQ-016 Push occurs when s_valid && s_ready; pop occurs when m_valid && m_ready.
REQ-017 s_ready = ren && !full && !rst_q, where rst_q is a register that is 1 during the cycle following reset assertion; it is derived from registered state only, never from s_valid or m_ready.
REQ-018 m_valid = !empty; m_data = mem[rd_ptr] when m_valid=1, else all zeros (first-word fall-through).
REQ-019 Latency: a word pushed at edge N is visible on m_data/m_valid immediately after edge N (one-cycle latency, no bubble).
REQ-020 Pointers wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH with no extra logic.
REQ-021 Simultaneous push and pop: count unchanged, both pointers advance, data order preserved.
REQ-022 Push only: count+1; pop only: count-1; count never exceeds DEPTH nor goes below 0.
REQ-023 full: s_ready=0, so a word offered with s_valid=1 is not accepted; a pop in the same cycle does not enable a push in that cycle.
REQ-024 empty: m_valid=0, a pop is impossible, and m_ready is ignored.
REQ-025 ren deasserted mid-stream: s_ready drops in the same cycle; buffered words continue to drain normally.
REQ-026 flush=1: pointers and count go to 0 and ovf_sticky clears at the next edge; a push or pop in the same cycle is discarded; s_ready=0 while flush=1.
REQ-027 Data ordering is strictly FIFO; no word is duplicated or lost except by flush or reset.
REQ-028 Buffer memory is not reset; its contents are unobservable because of REQ-018.

Reset
REQ-029 rst=1 at an edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, m_valid=0, m_data=0, ovf_sticky=0.
REQ-030 s_ready SHALL be 0 while rst=1 and for the first cycle after rst deasserts; from then on it follows REQ-017.
REQ-031 Reset asserted mid-transfer has priority over flush, push and pop; all buffered data is discarded.

Verification (L=8, DEPTH=4)
REQ-032 Reset, then ren=1, push 0x11,0x22,0x33 with m_ready=0 -> count=3, m_data=0x11, m_valid=1, s_ready=1.
REQ-033 Push 0xA0..0xA3 -> full=1, s_ready=0; hold s_valid=1 with 0xA4 -> ovf_sticky=1 and 0xA4 is never output; drain -> output is 0xA0,0xA1,0xA2,0xA3.
REQ-034 count=2, s_valid=1 and m_ready=1 for 10 cycles with incrementing data -> count stays 2, output order is gap-free, pointers wrap at least twice.
REQ-035 count=3, ren=0 with s_valid=1 -> s_ready=0 and count decrements to 0 as m_ready=1 drains 3 words; no new word is accepted.
REQ-036 count=3, flush=1 together with s_valid=1 and m_ready=1 -> next cycle count=0, m_valid=0, m_data=0x00, ovf_sticky=0.
REQ-037 count=2, rst=1 for one cycle -> all outputs at reset values; s_ready=0 that cycle and the next, then 1 with ren=1.

Source files
------------

// File: rtl/hs_slave_fifo.sv
// hs_slave_fifo: first-word fall-through slave buffer with a receive enable,
// a synchronous flush and a sticky overflow flag.
module hs_slave_fifo #(
    parameter int unsigned L     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ren,
    input  logic                     flush,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [L-1:0]             s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [L-1:0]             m_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf_sticky
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [L-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_rst_q;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);

    // Acceptance depends only on registered state and control inputs, never
    // on the handshake inputs, so no combinational path s_valid/m_ready -> s_ready.
    assign s_ready  = ren && !w_full && !r_rst_q && !rst && !flush;
    assign m_valid  = !w_empty;
    assign m_data   = w_empty ? '0 : r_mem[r_rd_ptr];

    assign w_push   = s_valid && s_ready;
    assign w_pop    = m_valid && m_ready;

    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;
    assign ovf_sticky = r_ovf;

    // Control state: pointers, occupancy, overflow flag, post-reset blanking.
    always_ff @(posedge clk) begin
        r_rst_q <= rst;
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (s_valid && ren && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage array; left unreset since empty entries are masked on m_data.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

endmodule
